// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// cp0_pkg : CP0 register numbers, exception codes and field positions.
// Rev 1.0
// ============================================================================
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int STATUS_IE   = 0;
    localparam int STATUS_EXL  = 1;
    localparam int IM_LSB      = 10;
    localparam int IM_MSB      = 15;
    localparam int IP_LSB      = 10;
    localparam int IP_MSB      = 15;
    localparam int EXCCODE_LSB = 2;
    localparam int EXCCODE_MSB = 6;
    localparam int IRQ_FIELD_W = IP_MSB - IP_LSB + 1;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

endpackage : cp0_pkg
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// irq_sync : per-bit two-flop synchronizer for asynchronous level inputs.
// Rev 1.0
// ============================================================================
module irq_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule : irq_sync
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// exc_ctrl : CP0 exception responder (Status/Cause/EPC, redirect, mtc0/mfc0/eret).
// Rev 1.0
// ============================================================================
module exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          NUM_IRQ    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_ex,
    input  logic [31:0]        pc_ex,
    input  logic               overflow_ex,
    input  logic               break_ex,
    input  logic               syscall_ex,
    input  logic               ri_ex,
    input  logic               eret_ex,
    input  logic               mtc0_ex,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               exc_redirect,
    output logic [31:0]        exc_target,
    output logic               exl
);

    logic [NUM_IRQ-1:0]     irq_s;
    logic [IRQ_FIELD_W-1:0] ip;

    logic                   ie_d, ie_q;
    logic                   exl_d, exl_q;
    logic [IRQ_FIELD_W-1:0] im_d, im_q;
    logic [4:0]             exccode_d, exccode_q;
    logic [31:0]            epc_d, epc_q;

    logic                   int_take, sync_exc, exc_take;
    logic                   eret_take, mtc0_take;
    logic [4:0]             win_code;

    irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (irq_in),
        .sync_out (irq_s)
    );

    always_comb begin
        ip = '0;
        ip[NUM_IRQ-1:0] = irq_s;
    end

    // An interrupt pre-empts any synchronous cause; the EX instruction is cancelled.
    always_comb begin
        int_take  = valid_ex & ie_q & ~exl_q & (|(ip & im_q));
        sync_exc  = valid_ex & (ri_ex | overflow_ex | syscall_ex | break_ex);
        exc_take  = int_take | sync_exc;
        eret_take = valid_ex & eret_ex & ~exc_take;
        mtc0_take = valid_ex & mtc0_ex & ~exc_take;

        if (int_take)         win_code = EXC_INT;
        else if (ri_ex)       win_code = EXC_RI;
        else if (overflow_ex) win_code = EXC_OV;
        else if (syscall_ex)  win_code = EXC_SYS;
        else                  win_code = EXC_BP;
    end

    always_comb begin
        ie_d      = ie_q;
        exl_d     = exl_q;
        im_d      = im_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;

        if (exc_take) begin
            exccode_d = win_code;
            exl_d     = 1'b1;
            // Nested exceptions keep the original return address.
            if (!exl_q) epc_d = pc_ex;
        end else begin
            if (mtc0_take) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        ie_d  = cp0_wdata[STATUS_IE];
                        exl_d = cp0_wdata[STATUS_EXL];
                        im_d  = cp0_wdata[IM_MSB:IM_LSB];
                    end
                    CP0_CAUSE: exccode_d = cp0_wdata[EXCCODE_MSB:EXCCODE_LSB];
                    CP0_EPC:   epc_d     = cp0_wdata;
                    default: ;
                endcase
            end
            if (eret_take) exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            im_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            im_q      <= im_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        exc_redirect = 1'b0;
        exc_target   = '0;
        if (rst_n) begin
            if (exc_take) begin
                exc_redirect = 1'b1;
                exc_target   = EXC_VECTOR;
            end else if (eret_take) begin
                exc_redirect = 1'b1;
                exc_target   = epc_q;
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_STATUS: begin
                cp0_rdata[STATUS_IE]     = ie_q;
                cp0_rdata[STATUS_EXL]    = exl_q;
                cp0_rdata[IM_MSB:IM_LSB] = im_q;
            end
            CP0_CAUSE: begin
                cp0_rdata[EXCCODE_MSB:EXCCODE_LSB] = exccode_q;
                cp0_rdata[IP_MSB:IP_LSB]           = ip;
            end
            CP0_EPC: cp0_rdata = epc_q;
            default: ;
        endcase
    end

    assign exl = exl_q;

endmodule : exc_ctrl
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_exc_ctrl : scoreboard bench for exc_ctrl against a register-level model.
// Rev 1.0
// ============================================================================
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_ex;
    logic [31:0] pc_ex;
    logic        overflow_ex, break_ex, syscall_ex, ri_ex, eret_ex, mtc0_ex;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [5:0]  irq_in;
    logic        exc_redirect;
    logic [31:0] exc_target;
    logic        exl;

    always #5 clk = ~clk;

    exc_ctrl #(.EXC_VECTOR(32'h0000_0180), .NUM_IRQ(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_ex     (valid_ex),
        .pc_ex        (pc_ex),
        .overflow_ex  (overflow_ex),
        .break_ex     (break_ex),
        .syscall_ex   (syscall_ex),
        .ri_ex        (ri_ex),
        .eret_ex      (eret_ex),
        .mtc0_ex      (mtc0_ex),
        .cp0_addr     (cp0_addr),
        .cp0_wdata    (cp0_wdata),
        .cp0_rdata    (cp0_rdata),
        .irq_in       (irq_in),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .exl          (exl)
    );

    typedef struct {
        logic        redirect;
        logic [31:0] target;
        logic        exl;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [5:0] irq_lvl = '0;

    // Architectural model of the CP0 state.
    bit        m_ie, m_exl;
    bit [5:0]  m_im, m_ip, m_sync1;
    bit [4:0]  m_code;
    bit [31:0] m_epc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic bit m_int();
        return valid_ex && m_ie && !m_exl && ((m_ip & m_im) != 0);
    endfunction

    function automatic bit m_sync();
        return valid_ex && (ri_ex || overflow_ex || syscall_ex || break_ex);
    endfunction

    function automatic bit [4:0] m_winner();
        if (m_int())          return 5'd0;
        else if (ri_ex)       return 5'd10;
        else if (overflow_ex) return 5'd12;
        else if (syscall_ex)  return 5'd8;
        else                  return 5'd9;
    endfunction

    function automatic bit [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
            5'd13:   return {16'h0, m_ip, 3'b0, m_code, 2'b0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_im = 0; m_ip = 0; m_sync1 = 0; m_code = 0; m_epc = 0;
    endtask

    task automatic model_step();
        if (m_int() || m_sync()) begin
            m_code = m_winner();
            if (!m_exl) m_epc = pc_ex;
            m_exl = 1;
        end else if (valid_ex) begin
            if (mtc0_ex) begin
                case (cp0_addr)
                    5'd12: begin
                        m_ie  = cp0_wdata[0];
                        m_exl = cp0_wdata[1];
                        m_im  = cp0_wdata[15:10];
                    end
                    5'd13: m_code = cp0_wdata[6:2];
                    5'd14: m_epc  = cp0_wdata;
                    default: ;
                endcase
            end
            if (eret_ex) m_exl = 0;
        end
        m_ip    = m_sync1;
        m_sync1 = irq_in;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        bit   exc = m_int() || m_sync();
        bit   er  = valid_ex && eret_ex && !exc;
        e.redirect = exc || er;
        e.target   = exc ? 32'h180 : (er ? m_epc : 32'h0);
        e.exl      = m_exl;
        e.rdata    = m_read(cp0_addr);
        return e;
    endfunction

    // exc = {ri, ov, sys, brk}
    task automatic op(input logic v, input logic [31:0] pc, input logic [3:0] exc,
                      input logic er, input logic mt, input logic [4:0] addr,
                      input logic [31:0] wd);
        @(posedge clk);
        model_step();
        #1;
        valid_ex    = v;
        pc_ex       = pc;
        ri_ex       = exc[3];
        overflow_ex = exc[2];
        syscall_ex  = exc[1];
        break_ex    = exc[0];
        eret_ex     = er;
        mtc0_ex     = mt;
        cp0_addr    = addr;
        cp0_wdata   = wd;
        irq_in      = irq_lvl;
        sb_q.push_back(expect_now());
    endtask

    task automatic idle(input int n, input logic [4:0] addr);
        for (int i = 0; i < n; i++) op(0, 32'h0, 4'b0, 0, 0, addr, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("redirect", {31'b0, exc_redirect}, {31'b0, e.redirect});
                chk("target",   exc_target, e.target);
                chk("exl",      {31'b0, exl}, {31'b0, e.exl});
                chk("rdata",    cp0_rdata, e.rdata);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] ex;
        rst_n = 0; valid_ex = 0; pc_ex = 0; overflow_ex = 0; break_ex = 0;
        syscall_ex = 0; ri_ex = 0; eret_ex = 0; mtc0_ex = 0;
        cp0_addr = 5'd12; cp0_wdata = 0; irq_in = 0;
        model_reset();
        #3;
        chk("rst_status", cp0_rdata, 32'h0);
        cp0_addr = 5'd13; #1;
        chk("rst_cause", cp0_rdata, 32'h0);
        chk("rst_redirect", {31'b0, exc_redirect}, 32'h0);
        chk("rst_exl", {31'b0, exl}, 32'h0);
        #8 rst_n = 1;

        // Overflow then eret
        op(1, 32'h40, 4'b0100, 0, 0, 5'd14, 0);
        op(0, 0, 4'b0, 0, 0, 5'd14, 0);
        op(0, 0, 4'b0, 0, 0, 5'd13, 0);
        op(1, 32'h44, 4'b0, 1, 0, 5'd12, 0);
        op(0, 0, 4'b0, 0, 0, 5'd12, 0);
        op(0, 0, 4'b0, 0, 0, 5'd14, 0);

        // Interrupt enabled
        op(1, 32'h50, 4'b0, 0, 1, 5'd12, 32'h0000_1001);
        irq_lvl = 6'b000100;
        idle(3, 5'd13);
        op(1, 32'h200, 4'b0, 0, 0, 5'd13, 0);
        op(0, 0, 4'b0, 0, 0, 5'd14, 0);
        op(0, 0, 4'b0, 0, 0, 5'd13, 0);
        op(1, 32'h204, 4'b0, 1, 0, 5'd12, 0);

        // Interrupt with IE=0
        irq_lvl = 6'b0;
        idle(3, 5'd13);
        op(1, 32'h208, 4'b0, 0, 1, 5'd12, 32'h0000_1000);
        irq_lvl = 6'b000100;
        idle(3, 5'd13);
        op(1, 32'h20c, 4'b0, 0, 0, 5'd13, 0);

        // RI together with an enabled pending interrupt
        irq_lvl = 6'b0;
        idle(3, 5'd13);
        op(1, 32'h210, 4'b0, 0, 1, 5'd12, 32'h0000_1001);
        irq_lvl = 6'b000100;
        idle(3, 5'd13);
        op(1, 32'h300, 4'b1000, 0, 0, 5'd13, 0);
        op(0, 0, 4'b0, 0, 0, 5'd13, 0);
        irq_lvl = 6'b0;
        idle(3, 5'd13);
        op(1, 32'h304, 4'b0, 1, 0, 5'd12, 0);

        // Overflow and break together
        op(1, 32'h400, 4'b0101, 0, 0, 5'd13, 0);
        op(0, 0, 4'b0, 0, 0, 5'd13, 0);
        op(1, 32'h404, 4'b0, 1, 0, 5'd14, 0);

        // Syscall cancels a coincident mtc0 to EPC; break while EXL=1
        op(1, 32'h500, 4'b0010, 0, 1, 5'd14, 32'h1234);
        op(0, 0, 4'b0, 0, 0, 5'd14, 0);
        op(1, 32'h600, 4'b0001, 0, 0, 5'd14, 0);
        op(0, 0, 4'b0, 0, 0, 5'd13, 0);
        op(0, 0, 4'b0, 0, 0, 5'd14, 0);

        // mtc0 EPC followed by eret uses the new value
        op(1, 32'h604, 4'b0, 1, 0, 5'd14, 0);
        op(1, 32'h608, 4'b0, 0, 1, 5'd14, 32'h1234);
        op(1, 32'h60c, 4'b0, 1, 0, 5'd14, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) irq_lvl = 6'($urandom);
            ex = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
            op($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, ex,
               $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
               5'(11 + $urandom_range(0, 4)), $urandom);
        end

        // Reset in the middle of a handler
        irq_lvl = 6'b0;
        idle(3, 5'd12);
        op(1, 32'h700, 4'b0, 1, 0, 5'd12, 0);
        op(1, 32'h704, 4'b0, 0, 1, 5'd12, 32'h0);
        op(1, 32'h80, 4'b0010, 0, 0, 5'd14, 0);
        op(0, 0, 4'b0, 0, 0, 5'd14, 0);
        @(negedge clk);
        #2;
        chk("pre_rst_exl", {31'b0, exl}, 32'h1);
        chk("pre_rst_epc", cp0_rdata, 32'h80);
        valid_ex = 1; overflow_ex = 1;
        rst_n = 0;
        #1;
        chk("mid_rst_exl", {31'b0, exl}, 32'h0);
        chk("mid_rst_epc", cp0_rdata, 32'h0);
        chk("mid_rst_redirect", {31'b0, exc_redirect}, 32'h0);
        chk("mid_rst_target", exc_target, 32'h0);
        cp0_addr = 5'd12; #1;
        chk("mid_rst_status", cp0_rdata, 32'h0);
        cp0_addr = 5'd13; #1;
        chk("mid_rst_cause", cp0_rdata, 32'h0);
        valid_ex = 0; overflow_ex = 0;
        model_reset();
        #1 rst_n = 1;
        op(0, 0, 4'b0, 0, 0, 5'd12, 0);
        op(1, 32'h900, 4'b0100, 0, 0, 5'd14, 0);
        op(0, 0, 4'b0, 0, 0, 5'd14, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_exc_ctrl
`default_nettype wire
